alu: RTL and testbench

64-bit integer arithmetic/logic unit for the I-type RISC-V datapath. It executes the operation selected by a 4-bit ALU-control code on two 64-bit operands (register or sign-extended immediate). It returns the result plus signed-overflow and zero flags. Outputs are registered, so the result is available one clock after the operands are presented; the Zero flag feeds branch evaluation.

---
 rtl/alu.sv | 104 ++++++++++
 tb/tb_alu.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// 64-bit RISC-V integer ALU with registered result, signed-overflow and zero flags.
// One operation is accepted every cycle; its outputs appear after the next rising edge.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [3:0]  OP,
  output logic [63:0] O,
  output logic        Ovf,
  output logic        Zero
);

  localparam int DATA_W = 64;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return (a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] d);
    return (a[DATA_W-1] != b[DATA_W-1]) && (d[DATA_W-1] != a[DATA_W-1]);
  endfunction

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic signed [DATA_W-1:0] sum_p0;
  logic signed [DATA_W-1:0] diff_p0;
  logic        [5:0]        shamt_p0;
  logic        [DATA_W-1:0] result_p0;
  logic                     ovf_p0;

  logic        [DATA_W-1:0] result_p1;
  logic                     ovf_p1;
  logic                     zero_p1;

  assign a_s      = A;
  assign b_s      = B;
  assign sum_p0   = a_s + b_s;
  assign diff_p0  = a_s - b_s;
  assign shamt_p0 = B[5:0];

  // Stage p0: combinational operation select; unlisted codes yield zero.
  always_comb begin
    result_p0 = '0;
    ovf_p0    = 1'b0;
    case (OP)
      OP_AND:  result_p0 = A & B;
      OP_OR:   result_p0 = A | B;
      OP_ADD:  begin
        result_p0 = sum_p0;
        ovf_p0    = add_ovf(a_s, b_s, sum_p0);
      end
      OP_XOR:  result_p0 = A ^ B;
      OP_SLL:  result_p0 = A << shamt_p0;
      OP_SRL:  result_p0 = A >> shamt_p0;
      OP_SUB:  begin
        result_p0 = diff_p0;
        ovf_p0    = sub_ovf(a_s, b_s, diff_p0);
      end
      OP_SLT:  result_p0 = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: result_p0 = {{(DATA_W-1){1'b0}}, (A < B)};
      OP_SRA:  result_p0 = a_s >>> shamt_p0;
      OP_NOR:  result_p0 = ~(A | B);
      default: begin
        result_p0 = '0;
        ovf_p0    = 1'b0;
      end
    endcase
  end

  // Stage p1: output register; Zero derives from the same next-state result as O.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_p1 <= '0;
      ovf_p1    <= 1'b0;
      zero_p1   <= 1'b1;
    end else begin
      result_p1 <= result_p0;
      ovf_p1    <= ovf_p0;
      zero_p1   <= (result_p0 == '0);
    end
  end

  assign O    = result_p1;
  assign Ovf  = ovf_p1;
  assign Zero = zero_p1;

endmodule

// File: tb/tb_alu.sv
// Bench for alu: a high-level arithmetic model checks every cycle under random stimulus,
// while directed literal cases pin both the model and the DUT.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [63:0] A;
  logic [63:0] B;
  logic [3:0]  OP;
  logic [63:0] O;
  logic        Ovf;
  logic        Zero;

  int checks = 0;
  int errors = 0;
  bit done   = 0;

  alu dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .OP   (OP),
    .O    (O),
    .Ovf  (Ovf),
    .Zero (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics: overflow means the true mathematical result lies outside the signed 64-bit range.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                                output logic [63:0] o, output logic ovf);
    longint sa;
    longint sb;
    longint r;
    int     sh;
    sa  = a;
    sb  = b;
    sh  = int'(b[5:0]);
    o   = 64'd0;
    ovf = 1'b0;
    case (op)
      4'd0:  o = a & b;
      4'd1:  o = a | b;
      4'd2:  begin
        o = a + b;
        r = o;
        ovf = (sa > 0 && sb > 0 && r < 0) || (sa < 0 && sb < 0 && r >= 0);
      end
      4'd3:  o = a ^ b;
      4'd4:  o = a << sh;
      4'd5:  o = a >> sh;
      4'd6:  begin
        o = a - b;
        r = o;
        ovf = (sa >= 0 && sb < 0 && r < 0) || (sa < 0 && sb > 0 && r >= 0);
      end
      4'd7:  o = (sa < sb) ? 64'd1 : 64'd0;
      4'd8:  o = (a < b) ? 64'd1 : 64'd0;
      4'd9:  begin
        r = sa >>> sh;
        o = r;
      end
      4'd12: o = ~(a | b);
      default: begin
        o   = 64'd0;
        ovf = 1'b0;
      end
    endcase
  endfunction

  // Every-cycle comparison against the model using the inputs sampled at the edge.
  always @(posedge clk) begin
    logic [63:0] eo;
    logic        ev;
    if (!done) begin
      if (reset) begin
        eo = 64'd0;
        ev = 1'b0;
      end else begin
        model(A, B, OP, eo, ev);
      end
      #1;
      chk("model_O", O, eo);
      chk("model_Ovf", {63'd0, Ovf}, {63'd0, ev});
      chk("model_Zero", {63'd0, Zero}, {63'd0, (eo == 64'd0)});
    end
  end

  task automatic step(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op);
    A  = a;
    B  = b;
    OP = op;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                     input logic [63:0] eo, input logic ev, input logic ez);
    step(a, b, op);
    chk({name, "_O"}, O, eo);
    chk({name, "_Ovf"}, {63'd0, Ovf}, {63'd0, ev});
    chk({name, "_Zero"}, {63'd0, Zero}, {63'd0, ez});
  endtask

  function automatic logic [63:0] rnd_operand();
    logic [63:0] corners [8];
    corners[0] = 64'd0;
    corners[1] = 64'd1;
    corners[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    corners[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    corners[4] = 64'h8000_0000_0000_0000;
    corners[5] = 64'h8000_0000_0000_0001;
    corners[6] = 64'd63;
    corners[7] = 64'd64;
    if ($urandom_range(3) == 0) return corners[$urandom_range(7)];
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b1;
    A     = 64'd2;
    B     = 64'd3;
    OP    = 4'b0010;
    @(negedge clk);
    chk("rst_O", O, 64'd0);
    chk("rst_Ovf", {63'd0, Ovf}, 64'd0);
    chk("rst_Zero", {63'd0, Zero}, 64'd1);
    reset = 1'b0;
    lit("post_rst_add", 64'd2, 64'd3, 4'b0010, 64'd5, 1'b0, 1'b0);

    lit("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
    lit("sub_zero", 64'd5, 64'd5, 4'b0110, 64'd0, 1'b0, 1'b1);
    lit("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    lit("and", 64'hF0F0, 64'h0FF0, 4'b0000, 64'h00F0, 1'b0, 1'b0);
    lit("or",  64'hF0F0, 64'h0FF0, 4'b0001, 64'hFFF0, 1'b0, 1'b0);
    lit("xor", 64'hF0F0, 64'h0FF0, 4'b0011, 64'hFF00, 1'b0, 1'b0);
    lit("nor", 64'hF0F0, 64'h0FF0, 4'b1100, 64'hFFFF_FFFF_FFFF_000F, 1'b0, 1'b0);
    lit("sll", 64'h8000_0000_0000_0001, 64'h41, 4'b0100, 64'h2, 1'b0, 1'b0);
    lit("srl", 64'h8000_0000_0000_0001, 64'h41, 4'b0101, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    lit("sra", 64'h8000_0000_0000_0001, 64'h41, 4'b1001, 64'hC000_0000_0000_0000, 1'b0, 1'b0);
    lit("sra0", 64'h8000_0000_0000_0001, 64'h40, 4'b1001, 64'h8000_0000_0000_0001, 1'b0, 1'b0);
    lit("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0111, 64'd1, 1'b0, 1'b0);
    lit("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1000, 64'd0, 1'b0, 1'b1);
    lit("b2b_add", 64'd2, 64'd3, 4'b0010, 64'd5, 1'b0, 1'b0);
    lit("b2b_sub", 64'd2, 64'd3, 4'b0110, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    lit("b2b_undef", 64'd2, 64'd3, 4'b1111, 64'd0, 1'b0, 1'b1);
    lit("undef_1010", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b1010, 64'd0, 1'b0, 1'b1);

    // Reset asserted alongside a real operation must win.
    reset = 1'b1;
    lit("rst_prio", 64'd7, 64'd9, 4'b0010, 64'd0, 1'b0, 1'b1);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(99) == 0);
      step(rnd_operand(), rnd_operand(), 4'($urandom_range(15)));
    end
    reset = 1'b0;

    done = 1'b1;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
